jtag_shift_ctrl: RTL and testbench

JTAG_SHIFT_CTRL -- requirements
Module: jtag_shift_ctrl

---
 rtl/jtag_shift_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_jtag_shift_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_ctrl.sv
// rtl/jtag_shift_ctrl.sv - JTAG TAP command sequencer with divided TCK generation
// Each op walks the TAP as header, shift and trailer phases and ends in Run-Test/Idle.
module jtag_shift_ctrl #(
  parameter int IR_LEN  = 5,
  parameter int TCK_DIV = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [31:0]       cmd_dr,
  input  logic [4:0]        cmd_len,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {INIT, IDLE, HDR, SHIFT, TRL, DONE} state_t;

  state_t           state_q, state_d, nxt_state;
  logic [5:0]       idx_q, idx_d, nxt_idx;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       len_q, len_d;
  logic [31:0]      data_q, data_d, acc_q, acc_d, rsp_data_q, rsp_data_d;
  logic             rsp_en_q, rsp_en_d, rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic [5:0]       shift_last;

  // Header-only ops (TAP reset, run-idle) and INIT use the HDR pattern as the whole op.
  function automatic logic [5:0] hdr_last(input logic [1:0] op, input logic [4:0] len);
    case (op)
      OP_RST:  return 6'd5;
      OP_IR:   return 6'd3;
      OP_DR:   return 6'd2;
      default: return {1'b0, len};
    endcase
  endfunction

  function automatic logic hdr_tms(input logic [1:0] op, input logic [5:0] idx);
    case (op)
      OP_RST:  return idx != 6'd5;
      OP_IR:   return idx < 6'd2;
      OP_DR:   return idx == 6'd0;
      default: return 1'b0;
    endcase
  endfunction

  assign shift_last = (op_q == OP_IR) ? 6'(IR_LEN - 1) : {1'b0, len_q};

  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q + 6'd1;
    case (state_q)
      INIT, HDR: begin
        if (idx_q == hdr_last(op_q, len_q)) begin
          nxt_idx   = 6'd0;
          nxt_state = (state_q == INIT || op_q == OP_RST || op_q == OP_IDLE) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == shift_last) begin
          nxt_idx   = 6'd0;
          nxt_state = TRL;
        end
      end
      TRL: begin
        if (idx_q == 6'd1) begin
          nxt_idx   = 6'd0;
          nxt_state = DONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    div_d       = div_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    acc_d       = acc_q;
    rsp_en_d    = rsp_en_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = HDR;
          idx_d       = 6'd0;
          div_d       = '0;
          tck_d       = 1'b0;
          tms_d       = hdr_tms(cmd_op, 6'd0);
          tdi_d       = 1'b0;
          op_d        = cmd_op;
          len_d       = cmd_len;
          data_d      = (cmd_op == OP_IR) ? 32'(cmd_ir) : cmd_dr;
          acc_d       = '0;
          rsp_en_d    = 1'b1;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        rsp_valid_d = rsp_en_q;
        if (rsp_en_q) rsp_data_d = acc_q;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            if (state_q == SHIFT) acc_d[idx_q[4:0]] = TDO;
          end else begin
            // Falling TCK closes a period: load the next period's TMS/TDI.
            state_d = nxt_state;
            idx_d   = nxt_idx;
            case (nxt_state)
              INIT, HDR: tms_d = hdr_tms(op_q, nxt_idx);
              SHIFT:     tms_d = (nxt_idx == shift_last);
              TRL:       tms_d = (nxt_idx == 6'd0);
              default:   tms_d = 1'b0;
            endcase
            tdi_d = (nxt_state == SHIFT) ? data_q[nxt_idx[4:0]] : 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= INIT;
      idx_q       <= 6'd0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      op_q        <= OP_RST;
      len_q       <= 5'd0;
      data_q      <= '0;
      acc_q       <= '0;
      rsp_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      rsp_en_q    <= rsp_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
// tb/tb_jtag_shift_ctrl.sv - scoreboard bench for jtag_shift_ctrl with a TDI->TDO loopback TAP
module tb_jtag_shift_ctrl;
  localparam int IR_LEN  = 5;
  localparam int TCK_DIV = 2;

  logic              clk = 1'b0;
  logic              nRST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IR_LEN-1:0] cmd_ir;
  logic [31:0]       cmd_dr;
  logic [4:0]        cmd_len;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              busy;
  logic              TCK, TMS, TDI, TDO;
  logic              tdo_dly = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          viol = 0;
  int          idle_viol = 0;
  logic [63:0] tms_v = '0;
  logic [63:0] tdi_v = '0;
  int          tms_n = 0;
  int          rise_q[$];
  logic        tck_prev = 1'b0;
  logic        tms_prev = 1'b0;
  logic        tdi_prev = 1'b0;

  jtag_shift_ctrl #(.IR_LEN(IR_LEN), .TCK_DIV(TCK_DIV)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ir    (cmd_ir),
    .cmd_dr    (cmd_dr),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge TCK) tdo_dly <= TDI;
  assign TDO = tdo_dly;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Per-TCK-period log, plus pin-behaviour watchers
  always @(negedge clk) begin
    if (TCK && !tck_prev) begin
      tms_v = {tms_v[62:0], TMS};
      tdi_v = {tdi_v[62:0], TDI};
      tms_n++;
      rise_q.push_back(cyc);
    end
    if (nRST && tck_prev && TCK && (TMS != tms_prev || TDI != tdi_prev)) viol++;
    if (nRST && cmd_ready && (TCK || TMS || TDI)) idle_viol++;
    tck_prev = TCK;
    tms_prev = TMS;
    tdi_prev = TDI;
  end

  // Response monitor
  always @(negedge clk) begin
    if (nRST && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_latency", 64'(cyc), 64'(e.due));
        chk("end_tck_low", 64'(TCK), 64'd0);
        chk("end_tms_low", 64'(TMS), 64'd0);
        chk("ready_with_rsp", 64'(cmd_ready), 64'd1);
      end
    end
  end

  task automatic clear_logs();
    tms_v = '0;
    tdi_v = '0;
    tms_n = 0;
    rise_q.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [IR_LEN-1:0] ir, input logic [31:0] dr,
                       input logic [4:0] len, input logic [31:0] want, input int n_per,
                       output int acc);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_len   = len;
    while (!cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    acc    = cyc;
    e.data = want;
    e.due  = acc + 2 * TCK_DIV * n_per + 1;
    sb.push_back(e);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_ir    = ~ir;
    cmd_dr    = ~dr;
    cmd_len   = ~len;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("ready_after_accept", 64'(cmd_ready), 64'd0);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("rsp_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic release_and_init();
    int c0;
    int guard;
    clear_logs();
    @(negedge clk);
    nRST  = 1'b1;
    c0    = cyc;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("init_ready_cycle", 64'(cyc - c0), 64'd25);
    chk("init_periods", 64'(tms_n), 64'd6);
    chk("init_tms_seq", tms_v, 64'b111110);
    chk("init_busy_low", 64'(busy), 64'd0);
    if (rise_q.size() == 6) begin
      chk("init_first_rise", 64'(rise_q[0] - c0), 64'd2);
      chk("init_last_rise", 64'(rise_q[5] - c0), 64'd22);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int a1, a2, guard;
    nRST      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_ir    = '0;
    cmd_dr    = '0;
    cmd_len   = '0;
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(TCK), 64'd0);
    chk("rst_tms", 64'(TMS), 64'd1);
    chk("rst_tdi", 64'(TDI), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);

    release_and_init();

    clear_logs();
    issue(2'b01, 5'b10110, 32'hDEAD_BEEF, 5'd7, 32'h0000_000C, IR_LEN + 6, a1);
    wait_done();
    chk("ir_periods", 64'(tms_n), 64'd11);
    chk("ir_tms_seq", tms_v, 64'b11000000110);
    chk("ir_tdi_seq", tdi_v, 64'b00000110100);

    clear_logs();
    issue(2'b10, '0, 32'hA5A5_0F0F, 5'd31, 32'h4B4A_1E1E, 37, a1);
    wait_done();
    chk("dr32_periods", 64'(tms_n), 64'd37);
    chk("dr32_tms_tail", tms_v & 64'h3F, 64'b000110);

    clear_logs();
    issue(2'b10, '0, 32'hFFFF_FFFF, 5'd0, 32'h0, 6, a1);
    wait_done();
    chk("dr1_periods", 64'(tms_n), 64'd6);
    chk("dr1_tms_seq", tms_v, 64'b100110);
    chk("dr1_tdi_seq", tdi_v, 64'b000100);

    clear_logs();
    issue(2'b11, '0, 32'h0, 5'd3, 32'h0, 4, a1);
    issue(2'b00, '0, 32'hFFFF_FFFF, 5'd9, 32'h0, 6, a2);
    chk("b2b_accept_gap", 64'(a2 - a1), 64'd18);
    wait_done();
    chk("b2b_periods", 64'(tms_n), 64'd10);
    chk("b2b_tms_seq", tms_v, 64'b0000111110);

    clear_logs();
    issue(2'b10, '0, 32'h1234_5678, 5'd31, 32'h0, 37, a1);
    guard = 0;
    while (tms_n < 11 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_bit7", 64'(tms_n), 64'd11);
    chk("abort_pre_tck_high", 64'(TCK), 64'd1);
    #3;
    nRST = 1'b0;
    sb.delete();
    #1;
    chk("abort_tck", 64'(TCK), 64'd0);
    chk("abort_tms", 64'(TMS), 64'd1);
    chk("abort_tdi", 64'(TDI), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_ready", 64'(cmd_ready), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    release_and_init();

    clear_logs();
    issue(2'b11, '0, 32'h0, 5'd0, 32'h0, 1, a1);
    wait_done();
    chk("idle1_periods", 64'(tms_n), 64'd1);
    repeat (10) @(negedge clk);

    chk("tms_tdi_stable_while_tck_high", 64'(viol), 64'd0);
    chk("idle_pins_low", 64'(idle_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
